// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: keeps one fetch in flight, buffers one word while ID stalls,
// and follows redirects from the PC unit by dropping stale responses.
module ysyx_22050854_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump,
  input  logic [31:0] next_pc,
  input  logic        Data_Conflict,
  input  logic        suspend,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        IDreg_valid,
  output logic [31:0] IDreg_pc,
  output logic [31:0] IDreg_inst
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HELD} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_addr;
  logic [31:0] buf_inst;
  logic        discard;

  logic        consume;
  logic        redirect;
  logic        req_fire;
  logic        id_free;
  logic        id_load;
  logic [31:0] id_load_inst;

  assign consume  = IDreg_valid & ~Data_Conflict & ~suspend;
  assign redirect = consume & (jump | (next_pc != fetch_addr));
  assign req_fire = imem_req_valid & imem_req_ready;
  assign id_free  = ~IDreg_valid | consume;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= S_REQ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_REQ:   if (req_fire) state_next = S_WAIT;
      S_WAIT:  if (imem_rsp_valid)
                 state_next = (discard | redirect | id_free) ? S_REQ : S_HELD;
      S_HELD:  if (consume) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    imem_req_valid = (state == S_REQ);
    imem_req_addr  = fetch_addr;
    id_load        = 1'b0;
    id_load_inst   = imem_rsp_data;
    case (state)
      S_WAIT:  id_load = imem_rsp_valid & ~discard & ~redirect & id_free;
      S_HELD: begin
        id_load      = consume & ~redirect;
        id_load_inst = buf_inst;
      end
      default: ;
    endcase
  end

  // A load and a redirect never coincide: a load requires the redirect to be absent.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_addr  <= RESET_PC;
      discard     <= 1'b0;
      buf_inst    <= '0;
      IDreg_valid <= 1'b0;
      IDreg_pc    <= '0;
      IDreg_inst  <= '0;
    end else begin
      if (id_load) begin
        IDreg_valid <= 1'b1;
        IDreg_pc    <= fetch_addr;
        IDreg_inst  <= id_load_inst;
      end else if (consume) begin
        IDreg_valid <= 1'b0;
      end

      if (redirect)     fetch_addr <= next_pc;
      else if (id_load) fetch_addr <= fetch_addr + 32'd4;

      case (state)
        S_REQ:   if (redirect & req_fire) discard <= 1'b1;
        S_WAIT: begin
          // The in-flight word was fetched for the old path once a redirect is seen.
          if (imem_rsp_valid)  discard <= 1'b0;
          else if (redirect)   discard <= 1'b1;
          if (imem_rsp_valid & ~discard & ~redirect & ~id_free) buf_inst <= imem_rsp_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Self-checking bench: a memory model answers fetches, and a scoreboard expects each
// instruction entering ID to sit at the next_pc given when its predecessor left ID.
module tb_ysyx_22050854_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clock;
  logic        reset;
  logic        jump;
  logic [31:0] next_pc;
  logic        Data_Conflict;
  logic        suspend;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        IDreg_valid;
  logic [31:0] IDreg_pc;
  logic [31:0] IDreg_inst;

  ysyx_22050854_ifu #(.RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .jump           (jump),
    .next_pc        (next_pc),
    .Data_Conflict  (Data_Conflict),
    .suspend        (suspend),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .IDreg_valid    (IDreg_valid),
    .IDreg_pc       (IDreg_pc),
    .IDreg_inst     (IDreg_inst)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks;
  int errors;
  int loaded;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // Memory contents: every address holds a distinct word derived from the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  // Scoreboard of expected ID pcs and log of transferred request addresses.
  logic [31:0] sb_q[$];
  logic [31:0] req_log[$];
  logic [31:0] model_pc;

  // Stimulus knobs.
  int          id_mode;      // 0 random, 1 hold, 2 sequential consume, 3 one-shot jump
  int          fire_when;    // 0 when ID valid, 1 while waiting with no response, 2 with response
  bit          fired;
  logic [31:0] jt;
  bit          rdy_always;
  bit          garbage_en;
  bit          late_rsp;
  int          lat_min;
  int          lat_max;

  // Memory model state.
  bit          pending;
  bit          rsp_real;
  bit          hs_armed;
  bit          prev_reset;
  logic [31:0] pend_addr;
  logic [31:0] hs_addr;
  int          delay;

  task automatic drive_cycle();
    bit rsp_now;
    bit cons;
    if (prev_reset) begin
      pending  = 1'b0;
      rsp_real = 1'b0;
      hs_armed = 1'b0;
    end
    if (rsp_real) pending = 1'b0;
    if (hs_armed) begin
      pending   = 1'b1;
      pend_addr = hs_addr;
      delay     = int'($urandom_range(lat_max, lat_min));
      req_log.push_back(hs_addr);
    end
    if (!reset) check_b("one_outstanding", pending && imem_req_valid, 1'b0);

    imem_req_ready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    rsp_real       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (reset) begin
    end else if (pending) begin
      if (delay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_at(pend_addr);
        rsp_real       = 1'b1;
      end else begin
        delay--;
      end
    end else if (late_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      late_rsp       = 1'b0;
    end else if (garbage_en) begin
      imem_rsp_valid = ($urandom_range(0, 3) == 0);
    end
    rsp_now  = rsp_real;
    hs_armed = !reset && imem_req_valid && imem_req_ready;
    hs_addr  = imem_req_addr;

    Data_Conflict = 1'b0;
    suspend       = 1'b1;
    jump          = 1'b0;
    next_pc       = model_pc + 32'd4;
    if (!reset) begin
      case (id_mode)
        0: begin
          Data_Conflict = ($urandom_range(0, 4) == 0);
          suspend       = ($urandom_range(0, 4) == 0);
          case ($urandom_range(0, 9))
            0: jump = 1'b1;
            1, 2: begin
              jump    = 1'($urandom_range(0, 1));
              next_pc = RESET_PC + ($urandom_range(0, 63) << 2);
            end
            3: begin
              jump    = 1'($urandom_range(0, 1));
              next_pc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            end
            default: ;
          endcase
        end
        2: suspend = 1'b0;
        3: if (!fired && IDreg_valid &&
               (fire_when == 0 || (fire_when == 1 && pending && !rsp_now) ||
                (fire_when == 2 && rsp_now))) begin
             suspend = 1'b0;
             jump    = 1'b1;
             next_pc = jt;
             fired   = 1'b1;
           end
        default: ;
      endcase
    end
    cons = !reset && IDreg_valid && !Data_Conflict && !suspend;
    if (cons) begin
      sb_q.push_back(next_pc);
      model_pc = next_pc;
    end
    prev_reset = reset;
  endtask

  task automatic step();
    @(negedge clock);
    #1;
    drive_cycle();
  endtask

  task automatic apply_reset(input bit late);
    reset    = 1'b1;
    pending  = 1'b0;
    rsp_real = 1'b0;
    hs_armed = 1'b0;
    sb_q.delete();
    req_log.delete();
    repeat (2) step();
    @(negedge clock);
    #1;
    reset    = 1'b0;
    model_pc = RESET_PC;
    sb_q.delete();
    sb_q.push_back(RESET_PC);
    late_rsp = late;
    fired    = 1'b0;
    drive_cycle();
  endtask

  task automatic wait_fired(input string name);
    for (int i = 0; i < 60 && !fired; i++) step();
    check_b(name, fired, 1'b1);
  endtask

  task automatic wait_req(input int n, input string name);
    for (int i = 0; i < 60 && req_log.size() < n; i++) step();
    check_b(name, req_log.size() >= n, 1'b1);
  endtask

  // Monitor: detects each new ID instruction and compares it with the scoreboard head.
  initial begin
    bit          last_valid;
    bit          consumed;
    logic [31:0] last_pc;
    logic [31:0] last_inst;
    logic [31:0] exp_pc;
    last_valid = 1'b0;
    last_pc    = '0;
    last_inst  = '0;
    @(posedge clock);
    forever begin
      @(negedge clock);
      if (reset) begin
        check_b("rst_id_valid", IDreg_valid, 1'b0);
        check("rst_id_pc", IDreg_pc, 32'h0);
        check("rst_id_inst", IDreg_inst, 32'h0);
        check_b("rst_req_valid", imem_req_valid, 1'b1);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        last_valid = 1'b0;
      end else begin
        consumed = last_valid && !Data_Conflict && !suspend;
        if (last_valid && !consumed) begin
          check_b("hold_valid", IDreg_valid, 1'b1);
          check("hold_pc", IDreg_pc, last_pc);
          check("hold_inst", IDreg_inst, last_inst);
        end else if (IDreg_valid) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_instr_pc", IDreg_pc, 32'hxxxx_xxxx);
          end else begin
            exp_pc = sb_q.pop_front();
            check("id_pc", IDreg_pc, exp_pc);
            check("id_inst", IDreg_inst, word_at(exp_pc));
            loaded++;
          end
        end
        last_valid = IDreg_valid;
        last_pc    = IDreg_pc;
        last_inst  = IDreg_inst;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    logic [31:0] p0;
    checks = 0; errors = 0; loaded = 0;
    reset = 1'b1; jump = 1'b0; next_pc = '0; Data_Conflict = 1'b0; suspend = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_mode = 2; fire_when = 0; fired = 1'b0; jt = '0;
    rdy_always = 1'b1; garbage_en = 1'b0; late_rsp = 1'b0; lat_min = 0; lat_max = 0;
    pending = 1'b0; rsp_real = 1'b0; hs_armed = 1'b0; prev_reset = 1'b1;
    pend_addr = '0; hs_addr = '0; delay = 0; model_pc = RESET_PC;

    // Sequential start-up with single-cycle memory.
    apply_reset(1'b0);
    wait_req(2, "startup_req_timeout");
    check("startup_req0", req_log[0], RESET_PC);
    check("startup_req1", req_log[1], RESET_PC + 32'd4);

    // ID stalled: prefetched word is held and no request issues; release without bubble.
    id_mode = 1;
    repeat (10) step();
    check_b("held_no_req_a", imem_req_valid, 1'b0);
    step();
    check_b("held_no_req_b", imem_req_valid, 1'b0);
    p0 = model_pc;
    id_mode = 2;
    step();
    step();
    check_b("held_release_valid", IDreg_valid, 1'b1);
    check("held_release_pc", IDreg_pc, p0 + 32'd4);

    // Jump while a fetch is in flight: stale word dropped, ID empty, then new target.
    lat_min = 3; lat_max = 3;
    id_mode = 3; fire_when = 1; jt = 32'h8000_0100; fired = 1'b0;
    wait_fired("jump_wait_fire");
    step();
    check_b("jump_wait_bubble", IDreg_valid, 1'b0);
    id_mode = 2;
    idx = req_log.size();
    wait_req(idx + 1, "jump_wait_req_timeout");
    check("jump_wait_req", req_log[idx], 32'h8000_0100);

    // Redirect coinciding with a response: word dropped, target requested next cycle.
    lat_min = 0; lat_max = 0;
    id_mode = 3; fire_when = 2; jt = 32'h8000_0200; fired = 1'b0;
    wait_fired("rsp_redir_fire");
    step();
    check_b("rsp_redir_req_valid", imem_req_valid, 1'b1);
    check("rsp_redir_req_addr", imem_req_addr, 32'h8000_0200);
    id_mode = 2;

    // Sequential fetch across the top of the address space.
    id_mode = 3; fire_when = 0; jt = 32'hFFFF_FFFC; fired = 1'b0;
    wait_fired("wrap_fire");
    id_mode = 2;
    step();
    idx = req_log.size();
    wait_req(idx + 2, "wrap_req_timeout");
    check("wrap_req_top", req_log[idx], 32'hFFFF_FFFC);
    check("wrap_req_zero", req_log[idx + 1], 32'h0000_0000);

    // Reset while a fetch is outstanding, with the old response arriving afterwards.
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 20 && !pending; i++) step();
    check_b("rst_wait_pending", pending, 1'b1);
    apply_reset(1'b1);
    lat_min = 0; lat_max = 0;
    wait_req(1, "rst_wait_req_timeout");
    check("rst_wait_first_req", req_log[0], RESET_PC);
    repeat (8) step();

    // Randomized traffic with stalls, redirects, stray responses and resets.
    rdy_always = 1'b0; garbage_en = 1'b1; lat_min = 0; lat_max = 3; id_mode = 0;
    for (int r = 0; r < 4; r++) begin
      repeat (1500) step();
      if (r < 3) apply_reset(1'($urandom_range(0, 1)));
    end
    garbage_en = 1'b0;
    id_mode    = 2;
    repeat (30) step();
    check_b("progress", loaded > 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
